// File: rtl/pk_reader_pkg.sv
// pk_reader_pkg: shared types and sizing helpers for the public-key reader.
// Holds the FSM state type, FIFO depth and width/count helper functions.
package pk_reader_pkg;

    // Output FIFO depth; also bounds FIFO words plus reads in flight.
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Word-address width of the L x K matrix stored as N-bit words.
    function automatic int addr_width(input int n, input int l, input int k);
        int words;
        words = l * k / n;
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // Words per row of the non-identity part.
    function automatic int words_per_row(input int n, input int l, input int k);
        return (k - l) / n;
    endfunction

    // Words emitted in one readout.
    function automatic int total_words(input int n, input int l, input int k);
        return l * (k - l) / n;
    endfunction

endpackage

// File: rtl/pk_fifo.sv
// pk_fifo: small synchronous FIFO, FIFO_DEPTH entries, async active-high reset.
// Ports: clk, rst, push/push_data, pop, head (entry at read pointer), empty, count.
module pk_fifo
    import pk_reader_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  logic [WIDTH-1:0]                     push_data,
    input  logic                                 pop,
    output logic [WIDTH-1:0]                     head,
    output logic                                 empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is allowed only when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pk_reader.sv
// pk_reader: streams the non-identity column blocks of the systemizer matrix
// row-major from word memory. Ports: clk, rst, start, busy, done, mem_rd_*,
// out_valid/out_ready handshake with out_data, out_eor (end of row), out_last.
module pk_reader
    import pk_reader_pkg::*;
#(
    parameter int N = 4,
    parameter int L = 8,
    parameter int K = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          mem_rd_en,
    output logic [addr_width(N,L,K)-1:0]  mem_rd_addr,
    input  logic [N-1:0]                  mem_rd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N-1:0]                  out_data,
    output logic                          out_eor,
    output logic                          out_last
);

    localparam int AW   = addr_width(N, L, K);
    localparam int W    = words_per_row(N, L, K);
    localparam int BASE = (L / N) * L;
    localparam int RW   = (L > 1) ? $clog2(L) : 1;
    localparam int CW   = (W > 1) ? $clog2(W) : 1;
    localparam int FCW  = $clog2(FIFO_DEPTH + 1);

    state_t          state;
    logic [AW-1:0]   nxt_addr;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;

    // Tags travel with each read: stage 1 beside mem_rd_en, stage 2 beside data.
    logic            rd_eor;
    logic            rd_last;
    logic            dvalid;
    logic            d_eor;
    logic            d_last;

    logic [FCW-1:0]  fcount;
    logic            fempty;
    logic [N+1:0]    head;

    logic [FCW-1:0]  pending;
    logic            room;
    logic            first;
    logic            issue;
    logic [AW-1:0]   cur_addr;
    logic [RW-1:0]   cur_row;
    logic [CW-1:0]   cur_col;
    logic            row_end;
    logic            last_rd;
    logic            pop;
    logic            last_hs;

    // FIFO words plus both read pipeline stages; never allowed to pass 4.
    assign pending  = fcount + FCW'(mem_rd_en) + FCW'(dvalid);
    assign room     = (pending < FCW'(FIFO_DEPTH));
    assign first    = (state == IDLE);
    // The first read goes out on the start edge so data appears on cycle 3.
    assign issue    = (first && start) || ((state == RUN) && room);
    assign cur_addr = first ? AW'(BASE) : nxt_addr;
    assign cur_row  = first ? '0 : row;
    assign cur_col  = first ? '0 : col;
    assign row_end  = (cur_col == CW'(W - 1));
    assign last_rd  = row_end && (cur_row == RW'(L - 1));

    assign out_valid = !fempty;
    assign out_data  = head[N-1:0];
    assign out_eor   = !fempty && head[N];
    assign out_last  = !fempty && head[N+1];
    assign pop       = out_valid && out_ready;
    assign last_hs   = pop && out_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            nxt_addr    <= '0;
            row         <= '0;
            col         <= '0;
            rd_eor      <= 1'b0;
            rd_last     <= 1'b0;
            dvalid      <= 1'b0;
            d_eor       <= 1'b0;
            d_last      <= 1'b0;
        end else begin
            done      <= 1'b0;
            mem_rd_en <= issue;
            dvalid    <= mem_rd_en;
            d_eor     <= rd_eor;
            d_last    <= rd_last;
            if (issue) begin
                mem_rd_addr <= cur_addr;
                rd_eor      <= row_end;
                rd_last     <= last_rd;
                if (row_end) begin
                    // Next row restarts at the first non-identity block.
                    col      <= '0;
                    row      <= cur_row + 1'b1;
                    nxt_addr <= AW'(BASE) + AW'(cur_row) + AW'(1);
                end else begin
                    col      <= cur_col + 1'b1;
                    row      <= cur_row;
                    nxt_addr <= cur_addr + AW'(L);
                end
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue && last_rd) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        row      <= '0;
                        col      <= '0;
                        nxt_addr <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    pk_fifo #(
        .WIDTH (N + 2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (dvalid),
        .push_data ({d_last, d_eor, mem_rd_data}),
        .pop       (pop),
        .head      (head),
        .empty     (fempty),
        .count     (fcount)
    );

endmodule

// File: doc/pk_reader.md
PK_READER -- requirements
Module: pk_reader

Interface
REQ-001 Parameter N, default 4, word width in bits; N SHALL be at least 4.
REQ-002 Parameter L, default 8, matrix rows; L SHALL be a multiple of N.
REQ-003 Parameter K, default 16, matrix columns; K SHALL be a multiple of N and greater than L.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a readout.
REQ-007 busy  out  1  high from the cycle after an accepted start until done.
REQ-008 done  out  1  one-cycle pulse when readout completes.
REQ-009 mem_rd_en  out  1  read strobe to the systemizer matrix memory.
REQ-010 mem_rd_addr  out  clog2(L*K/N)  read word address.
REQ-011 mem_rd_data  in  N  read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 out_valid  out  1  out_data is valid.
REQ-013 out_ready  in  1  sink accepts the word when out_valid and out_ready are both high.
REQ-014 out_data  out  N  public-key word.
REQ-015 out_eor  out  1  qualifies out_data as the last word of a row.
REQ-016 out_last  out  1  qualifies out_data as the final word of the readout.

Function
REQ-017 Memory layout: column block b, row r is stored at address b*L + r.
REQ-018 The block SHALL emit only the non-identity part: blocks L/N..K/N-1, row-major, for r = 0..L-1 and, within each row, b = L/N..K/N-1.
REQ-019 Total words = L*(K-L)/N; W = (K-L)/N words per row.
REQ-020 Address generation is incremental with no multiplier: +L within a row; at end of row, reset to L/N*L + r+1.
REQ-021 FSM states are IDLE, RUN, DRAIN.
REQ-022 FSM transitions: IDLE->RUN on start; RUN->DRAIN after the last read is issued; DRAIN->IDLE on the out_last handshake.
REQ-023 start is ignored unless the state is IDLE.
REQ-024 Output buffering is a 4-entry FIFO that holds data, eor and last.
REQ-025 A read SHALL be issued in RUN only when FIFO occupancy plus in-flight reads is less than 4, so the FIFO never overflows.
REQ-026 Sustained out_ready=1 SHALL give one word per cycle after a 2-cycle start-up: first out_valid at the 3rd cycle after start.
REQ-027 out_valid = FIFO not empty; out_data, out_eor and out_last come from the FIFO head.
REQ-028 Held data SHALL stay stable while out_valid && !out_ready.
REQ-029 A simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-030 done SHALL pulse the cycle after the out_last handshake; busy SHALL fall in that same cycle.
REQ-031 mem_rd_en SHALL never be asserted outside RUN.
REQ-032 mem_rd_addr SHALL never exceed L*K/N-1.

Reset
REQ-033 rst SHALL force state IDLE, FIFO empty, in-flight count 0, and all address and row/column counters 0.
REQ-034 rst SHALL force busy, done, mem_rd_en, out_valid, out_eor and out_last to 0; mem_rd_addr and out_data SHALL reset to 0.
REQ-035 rst mid-readout SHALL abandon the readout; a read response arriving after rst is discarded.
REQ-036 The next start after rst SHALL restart from row 0.

Structure
REQ-037 The shared package SHALL hold the address-width function, words-per-row, total-words and FIFO-depth constants.
REQ-038 One sub-module, pk_fifo, SHALL implement the 4-entry synchronous FIFO (N+2 bits wide, async active-high reset).

Verification (N=4, L=12, K=24: W=3, 36 words, memory word at address a = a mod 16)
REQ-039 start with out_ready=1 -> mem_rd_addr sequence 36,48,60,37,49,61,...,47,59,71; 36 contiguous out_valid cycles; done pulses once.
REQ-040 Check qualifiers -> out_eor on words 3,6,...,36; out_last only on word 36.
REQ-041 out_ready held 0 for 10 cycles mid-row -> at most 4 reads outstanding, no word lost or duplicated, out_data stable.
REQ-042 out_ready toggling 1010... -> same 36-word sequence; mem_rd_en never asserted while occupancy + in-flight = 4.
REQ-043 Second start while busy -> ignored; exactly one done.
REQ-044 rst asserted after word 20 -> all outputs 0 the next cycle; a new start yields first word from address 36.
